// File: rtl/change_dispenser_if.sv
// Request, hopper-sensor and solenoid signals between the vend controller,
// the hopper driver board and change_dispenser.
interface change_dispenser_if;
  logic change1;
  logic change2;
  logic change22;
  logic coin1_sense;
  logic coin2_sense;
  logic fault_clr;
  logic eject1;
  logic eject2;
  logic busy;
  logic fault;
  logic overflow;

  modport master (
    output change1, change2, change22, coin1_sense, coin2_sense, fault_clr,
    input  eject1, eject2, busy, fault, overflow
  );

  modport slave (
    input  change1, change2, change22, coin1_sense, coin2_sense, fault_clr,
    output eject1, eject2, busy, fault, overflow
  );
endinterface

// File: rtl/change_dispenser.sv
// Coin payout back-end: queues owed coins per denomination and pulses the hopper
// solenoids one coin at a time with sensor confirmation and timeout.
// Optional feature: define CHANGE_DISPENSER_RETRY_EN to retry once after a timeout.
module change_dispenser #(
  parameter int unsigned CNT_W          = 4,
  parameter int unsigned PULSE_CYCLES   = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned GAP_CYCLES     = 4
) (
  input  logic              clk,
  input  logic              reset,
  change_dispenser_if.slave bus
);
  localparam int unsigned SUM_W  = CNT_W + 2;
  localparam int unsigned PG_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int unsigned PG_W   = $clog2(PG_MAX + 1);
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SUM_W-1:0] PEND_MAX = SUM_W'((1 << CNT_W) - 1);

  typedef enum logic [2:0] {S_IDLE, S_EJECT, S_WAIT_SENSE, S_GAP, S_FAULT} state_e;

  state_e            state_q, state_d;
  logic              sel_q, sel_d;          // 1: 2-ruble coin, 0: 1-ruble coin
  logic [PG_W-1:0]   cnt_q, cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              latched_q, latched_d;
  logic              retry_q, retry_d;
  logic [CNT_W-1:0]  pend1_q, pend1_d, pend2_q, pend2_d;
  logic [2:0]        sync1_q, sync1_d, sync2_q, sync2_d;
  logic              eject1_q, eject1_d, eject2_q, eject2_d;
  logic              busy_q, busy_d, fault_q, fault_d, overflow_q, overflow_d;

  logic              sense1_re, sense2_re, sel_re;
  logic              confirm, start_eject, start_sel, enter_eject;
  logic              dec1, dec2;
  logic [SUM_W-1:0]  sum1, sum2;

  // pend + add - dec in the wide domain, floored at zero
  function automatic logic [SUM_W-1:0] pend_next(input logic [CNT_W-1:0] pend,
                                                 input logic [SUM_W-1:0] add,
                                                 input logic dec);
    logic [SUM_W-1:0] s;
    s = SUM_W'(pend) + add;
    if (dec && (s != '0)) s = s - SUM_W'(1);
    return s;
  endfunction

  // Sensor synchronizers: bit0 meta, bit1 synced, bit2 previous synced value
  always_comb begin
    sync1_d   = {sync1_q[1:0], bus.coin1_sense};
    sync2_d   = {sync2_q[1:0], bus.coin2_sense};
    sense1_re = sync1_q[1] & ~sync1_q[2];
    sense2_re = sync2_q[1] & ~sync2_q[2];
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    to_cnt_d    = to_cnt_q;
    latched_d   = latched_q;
    retry_d     = retry_q;
    confirm     = 1'b0;
    enter_eject = 1'b0;
    dec1        = 1'b0;
    dec2        = 1'b0;
    sel_re      = sel_q ? sense2_re : sense1_re;

    // A pending retry keeps the same coin; otherwise the 2-ruble coin wins
    start_eject = 1'b0;
    start_sel   = sel_q;
    if (retry_q) begin
      start_eject = 1'b1;
    end else if (pend2_q != '0) begin
      start_eject = 1'b1;
      start_sel   = 1'b1;
    end else if (pend1_q != '0) begin
      start_eject = 1'b1;
      start_sel   = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start_eject) enter_eject = 1'b1;
      end
      S_EJECT: begin
        cnt_d    = cnt_q + PG_W'(1);
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (sel_re) latched_d = 1'b1;
        if (cnt_q == PG_W'(PULSE_CYCLES - 1)) begin
          if (latched_q || sel_re) confirm = 1'b1;
          else                     state_d = S_WAIT_SENSE;
        end
      end
      S_WAIT_SENSE: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (sel_re) begin
          confirm = 1'b1;
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
`ifdef CHANGE_DISPENSER_RETRY_EN
          if (!retry_q) begin
            retry_d = 1'b1;
            state_d = S_GAP;
            cnt_d   = '0;
          end else begin
            state_d = S_FAULT;
          end
`else
          state_d = S_FAULT;
`endif
        end
      end
      S_GAP: begin
        cnt_d = cnt_q + PG_W'(1);
        // Last gap cycle chooses the next coin directly so ejections are P+G apart
        if (cnt_q == PG_W'(GAP_CYCLES - 1)) begin
          if (start_eject) enter_eject = 1'b1;
          else             state_d     = S_IDLE;
        end
      end
      S_FAULT: begin
        if (bus.fault_clr) begin
          state_d = S_IDLE;
          retry_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (confirm) begin
      state_d = S_GAP;
      cnt_d   = '0;
      retry_d = 1'b0;
      dec1    = ~sel_q;
      dec2    = sel_q;
    end

    if (enter_eject) begin
      state_d   = S_EJECT;
      sel_d     = start_sel;
      cnt_d     = '0;
      to_cnt_d  = '0;
      latched_d = 1'b0;
    end
  end

  // Pending counters with saturation and sticky overflow
  always_comb begin
    sum1       = pend_next(pend1_q, SUM_W'(bus.change1), dec1);
    sum2       = pend_next(pend2_q, SUM_W'(bus.change2) + SUM_W'({bus.change22, 1'b0}), dec2);
    pend1_d    = (sum1 > PEND_MAX) ? PEND_MAX[CNT_W-1:0] : sum1[CNT_W-1:0];
    pend2_d    = (sum2 > PEND_MAX) ? PEND_MAX[CNT_W-1:0] : sum2[CNT_W-1:0];
    overflow_d = overflow_q | (sum1 > PEND_MAX) | (sum2 > PEND_MAX);
    eject1_d   = (state_d == S_EJECT) && !sel_d;
    eject2_d   = (state_d == S_EJECT) && sel_d;
    fault_d    = (state_d == S_FAULT);
    busy_d     = (state_d != S_IDLE) || (pend1_d != '0) || (pend2_d != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      sel_q      <= 1'b0;
      cnt_q      <= '0;
      to_cnt_q   <= '0;
      latched_q  <= 1'b0;
      retry_q    <= 1'b0;
      pend1_q    <= '0;
      pend2_q    <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      eject1_q   <= 1'b0;
      eject2_q   <= 1'b0;
      busy_q     <= 1'b0;
      fault_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      to_cnt_q   <= to_cnt_d;
      latched_q  <= latched_d;
      retry_q    <= retry_d;
      pend1_q    <= pend1_d;
      pend2_q    <= pend2_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      eject1_q   <= eject1_d;
      eject2_q   <= eject2_d;
      busy_q     <= busy_d;
      fault_q    <= fault_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.eject1   = eject1_q;
  assign bus.eject2   = eject2_q;
  assign bus.busy     = busy_q;
  assign bus.fault    = fault_q;
  assign bus.overflow = overflow_q;
endmodule

// File: doc/change_dispenser.md
# change_dispenser

Payout back-end for the vend controller: accepts its one-cycle change requests (change1, change2, change22), queues the owed coins per denomination, and drives the two coin-hopper solenoids one coin at a time. Each ejection is confirmed by the hopper's optical coin sensor, with a timeout. The block sits between the vend controller outputs and the hopper driver board.

## Interface
- CNT_W, 4: width of each pending-coin counter.
- PULSE_CYCLES, 8: solenoid pulse width in clk cycles, minimum 1.
- TIMEOUT_CYCLES, 1000: maximum cycles from EJECT entry to sensor confirmation; must exceed PULSE_CYCLES.
- GAP_CYCLES, 4: idle cycles between consecutive ejections, minimum 1.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- change1  in  1  request one 1-ruble coin; one-cycle pulse, synchronous to clk.
- change2  in  1  request one 2-ruble coin; one-cycle pulse.
- change22  in  1  request two 2-ruble coins; one-cycle pulse.
- coin1_sense  in  1  1-ruble hopper sensor; asynchronous, high while a coin passes.
- coin2_sense  in  1  2-ruble hopper sensor; asynchronous.
- fault_clr  in  1  one-cycle pulse that leaves FAULT.
- eject1  out  1  1-ruble solenoid drive; registered.
- eject2  out  1  2-ruble solenoid drive; registered.
- busy  out  1  high while any coin is pending or the FSM is not in IDLE.
- fault  out  1  high in FAULT.
- overflow  out  1  sticky; set when a pending counter saturates; cleared only by reset.

## Operation
- Request decode, per cycle:
  - add1 = change1.
  - add2 = change2 + 2·change22.
  - Any combination may be asserted together. change1 with change2 adds 1 coin to pend1 and 1 coin to pend2.
- Pending counters pend1 and pend2 are CNT_W bits wide. Each cycle: next = pend + add − dec, where dec is the confirmed ejection this cycle.
  - Compute in CNT_W+2 bits.
  - Saturate at 2^CNT_W−1 and set overflow when saturation occurs.
  - Never decrements below 0.
- Sensors: each passes through a two-flop synchronizer followed by rising-edge detection, giving sense1_re and sense2_re.
- FSM states: IDLE, EJECT, WAIT_SENSE, GAP, FAULT.
  - IDLE:
    - pend2≠0 → EJECT with sel=2.
    - Else pend1≠0 → EJECT with sel=1.
    - The larger denomination always has priority.
  - EJECT:
    - eject for sel is high for exactly PULSE_CYCLES cycles.
    - A sense edge for sel is latched.
    - At pulse end: latched → GAP; otherwise → WAIT_SENSE.
  - WAIT_SENSE:
    - sense edge for sel → GAP.
    - Timeout counter, started at EJECT entry, reaches TIMEOUT_CYCLES → retry or FAULT (see Configuration).
  - GAP: hold for GAP_CYCLES cycles → IDLE.
  - FAULT:
    - Both eject outputs are low.
    - Requests continue to accumulate in the pending counters.
    - fault_clr → IDLE; the failed coin is still pending.
- dec: the pending counter for sel decrements by 1 in the cycle the FSM enters GAP.
- Sense edges for the non-selected denomination, or any edge seen in IDLE, GAP or FAULT, are ignored.

## Timing
- Reset values: eject1, eject2, busy, fault, overflow all 0; pend1, pend2 = 0; state IDLE.
- Latency: a request sampled at edge k updates pend at edge k. The FSM enters EJECT at edge k+1, and eject is high from k+1 through k+PULSE_CYCLES.
- Sensor path: pad to sense_re takes 2–3 cycles of synchronizer delay.
- Per-coin minimum cycle time, when the sensor fires during the pulse: PULSE_CYCLES + GAP_CYCLES.
- A request in the same cycle as a decrement applies both: pend + add − 1.
- Reset mid-pulse: eject drops immediately (asynchronous reset) and all pending coins are discarded.
- At most one eject output is ever high. eject is never high outside EJECT.

## Configuration
- CHANGE_DISPENSER_RETRY_EN defined:
  - On the first timeout for a coin, go to GAP and re-enter EJECT for the same coin, restarting the timeout.
  - A second consecutive timeout for that coin → FAULT.
  - The retry flag clears on confirmation, fault_clr or reset.
- Not defined: the first timeout → FAULT.

## Test plan
- change22 pulse, sensor edge 3 cycles into each pulse → two eject2 pulses of 8 cycles each, separated by 4-cycle gaps; pend2 goes 2→1→0; busy falls after the last GAP.
- change1 and change2 asserted in the same cycle → eject2 first, then eject1; overflow stays 0.
- No sensor response, macro off → eject1 pulse of 8 cycles, then fault=1 at cycle 1000 after EJECT entry; fault_clr → a new eject1 pulse; pend1 is still 1.
- No sensor response, macro on → two eject pulses, then FAULT at roughly 2×1000 + 4 cycles.
- Seventeen change1 pulses with the sensor held low, CNT_W=4 → pend1 saturates at 15 and overflow=1.
- Reset asserted mid-pulse → eject2=0 immediately; all outputs at reset values; no ejection after reset is released.
